// File: rtl/vga_timing_gen.sv
// Video timing master: owns the pixel/line counters, exports x/y/active/next_frame
// to the pattern selector and registers hsync, vsync and colour to the pins.
module vga_timing_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       next_frame,
  input  logic [5:0] rgb_in,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS       = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS       = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_IDLE   = SYNC_ACTIVE_LOW;
  localparam logic       SYNC_PULSE  = ~SYNC_ACTIVE_LOW;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [5:0] rgb_q, rgb_d;

  // Decode from the counter registers; gated by rst so the selector sees a
  // quiet interface while reset is held.
  always_comb begin
    x          = h_cnt_q;
    y          = v_cnt_q;
    active     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS) && !rst;
    next_frame = (h_cnt_q == 10'd0) && (v_cnt_q == V_VIS) && !rst;
  end

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end

    hsync_d = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? SYNC_PULSE : SYNC_IDLE;
    vsync_d = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? SYNC_PULSE : SYNC_IDLE;
    rgb_d   = active ? rgb_in : 6'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      rgb_q   <= 6'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign rgb_out = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a shrunken timing set so several
// whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 8, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x, y;
  logic       active, next_frame, hsync, vsync;
  logic [5:0] rgb_in = 6'd0;
  logic [5:0] rgb_out;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active(active),
    .next_frame(next_frame), .rgb_in(rgb_in), .hsync(hsync),
    .vsync(vsync), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
  } pin_t;

  pin_t exp_q[$];

  int n_compared = 0;
  int n_mismatched = 0;
  int mh, mv, cycle;
  bit const_rgb, run_valid;
  int run_len;
  logic prev_hs, prev_vs;
  int last_hfall, last_vfall, last_nf;
  int nf_seen = 0;
  int nf_model = 0;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic reset_model();
    mh = 0;
    mv = 0;
    exp_q.delete();
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    last_hfall = -1;
    last_vfall = -1;
    last_nf = -1;
    run_len = 0;
  endtask

  // Called at a negedge: check what the DUT shows now, drive the next colour,
  // queue the pin values it must produce one clock later, then advance.
  task automatic applyStimulus();
    bit   e_act;
    pin_t p;
    e_act = (mh < HA) && (mv < VA);

    checkOutput("x", x, mh);
    checkOutput("y", y, mv);
    checkOutput("active", active, e_act);
    checkOutput("next_frame", next_frame, (mh == 0) && (mv == VA));
    if (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      checkOutput("rgb_out", rgb_out, p.rgb);
      checkOutput("hsync", hsync, p.hs);
      checkOutput("vsync", vsync, p.vs);
    end

    if (prev_hs && !hsync) begin
      checkOutput("hsync_fall_x", x, HA + HF + 1);
      if (last_hfall >= 0) checkOutput("h_period", cycle - last_hfall, HT);
      last_hfall = cycle;
    end
    if (!prev_hs && hsync && last_hfall >= 0) checkOutput("h_width", cycle - last_hfall, HS);

    if (prev_vs && !vsync) begin
      checkOutput("vsync_fall_y", y, VA + VF);
      if (last_vfall >= 0) checkOutput("v_period", cycle - last_vfall, FT);
      last_vfall = cycle;
    end
    if (!prev_vs && vsync && last_vfall >= 0) checkOutput("v_width", cycle - last_vfall, VS * HT);

    if (next_frame) begin
      nf_seen++;
      checkOutput("nf_x", x, 0);
      checkOutput("nf_y", y, VA);
      if (last_nf >= 0) checkOutput("nf_period", cycle - last_nf, FT);
      last_nf = cycle;
    end
    if (mh == 0 && mv == VA) nf_model++;

    if (rgb_out == 6'h3f) run_len++;
    else begin
      if (run_valid && run_len > 0) checkOutput("active_run", run_len, HA);
      run_len = 0;
    end

    prev_hs = hsync;
    prev_vs = vsync;

    rgb_in = const_rgb ? 6'h3f : 6'($urandom_range(0, 63));
    p.rgb = e_act ? rgb_in : 6'd0;
    p.hs  = (mh >= HA + HF && mh < HA + HF + HS) ? 1'b0 : 1'b1;
    p.vs  = (mv >= VA + VF && mv < VA + VF + VS) ? 1'b0 : 1'b1;
    exp_q.push_back(p);

    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    cycle++;
    @(negedge clk);
  endtask

  initial begin
    cycle = 0;
    const_rgb = 1'b0;
    run_valid = 1'b0;
    reset_model();

    repeat (3) @(negedge clk);
    checkOutput("rst_x", x, 0);
    checkOutput("rst_y", y, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_next_frame", next_frame, 0);
    checkOutput("rst_rgb_out", rgb_out, 0);
    checkOutput("rst_hsync", hsync, 1);
    checkOutput("rst_vsync", vsync, 1);

    rst = 1'b0;
    #1;
    checkOutput("post_rst_active", active, 1);
    repeat (FT) applyStimulus();

    // Model is back at (0,0): constant white for two frames.
    const_rgb = 1'b1;
    run_valid = 1'b1;
    run_len = 0;
    repeat (2 * FT) applyStimulus();
    const_rgb = 1'b0;
    run_valid = 1'b0;

    for (int i = 0; i < FT && !(mh == 10 && mv == 5); i++) applyStimulus();
    checkOutput("pre_rst_x", x, 10);
    checkOutput("pre_rst_y", y, 5);
    rgb_in = 6'b101010;
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_x", x, 0);
    checkOutput("mid_rst_y", y, 0);
    checkOutput("mid_rst_rgb_out", rgb_out, 0);
    checkOutput("mid_rst_hsync", hsync, 1);
    checkOutput("mid_rst_vsync", vsync, 1);
    checkOutput("mid_rst_active", active, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    reset_model();
    repeat (FT + HT) applyStimulus();

    checkOutput("nf_count", nf_seen, nf_model);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Video timing master that drives the common pattern generator interface and consumes its colour output. It owns the horizontal and vertical pixel counters and produces x, y, active and next_frame for the pattern selector. It takes the selected rgb back and drives registered hsync, vsync and rgb to the output pins. One instance sits at the top level, fed by the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0, 0 = sync pulses drive 1

Ports:
clk  input  1  pixel clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
x  output  10  current horizontal count, 0..H_TOTAL-1
y  output  10  current vertical count, 0..V_TOTAL-1
active  output  1  current (x,y) is inside the visible window
next_frame  output  1  single-cycle pulse once per frame
rgb_in  input  6  colour from the pattern selector for the current (x,y)
hsync  output  1  registered horizontal sync to the pin
vsync  output  1  registered vertical sync to the pin
rgb_out  output  6  registered colour to the pin

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must fit in 10 bits.
- Counters: h_cnt and v_cnt are registered. h_cnt increments every cycle.
  - When h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt = V_TOTAL-1 at the same time, v_cnt also wraps to 0.
- x = h_cnt and y = v_cnt, decoded combinationally from the counter registers.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). It is forced to 0 while rst is high.
- next_frame = 1 only when h_cnt = 0 and v_cnt = V_ACTIVE.
  - This gives exactly one pulse per frame, at the start of vertical blanking.
  - It is forced to 0 while rst is high.
- rgb_in is combinational from x, y and active within the same cycle.
- Output pipeline (1 register stage):
  - rgb_out <= active ? rgb_in : 0.
  - hsync <= pulse level when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), idle level otherwise.
  - vsync <= pulse level when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), idle level otherwise.
  - All pin outputs therefore lag the counters by exactly 1 cycle.
- Pulse level = ~SYNC_ACTIVE_LOW; idle level = SYNC_ACTIVE_LOW.
- Reset values:
  - h_cnt = 0, v_cnt = 0, so x = 0 and y = 0.
  - active = 0, next_frame = 0.
  - rgb_out = 0.
  - hsync and vsync at idle level (1 with default parameters).
- Reset mid-frame: all state clears immediately, without waiting for a clock edge. The first cycle after release is h = 0, v = 0, active = 1.
- No blanking-period colour: rgb_out is 0 whenever the registered active is 0, regardless of rgb_in.

Test Plan:
- Reset check: hold rst -> rgb_out = 0, hsync = 1, vsync = 1, active = 0, next_frame = 0, x = 0, y = 0. On the first cycle after release -> x = 0, y = 0, active = 1.
- Line timing: run 3 lines -> hsync falling edges are 800 cycles apart, each low pulse is 96 cycles wide, and the fall occurs on the cycle after x = 656.
- Frame timing: run 2 frames -> vsync low for 1600 cycles (lines 490..491), frame period 420000 cycles. next_frame pulses exactly once per frame, with x = 0, y = 480.
- Active window: drive rgb_in = 6'b111111 constantly -> rgb_out = 111111 for 640 consecutive cycles per line on lines 0..479. rgb_out = 0 on the cycle after x = 640, and through all of lines 480..524.
- Wrap-around: at x = 799, y = 524 -> next cycle x = 0, y = 0, active = 1. At x = 799, y = 10 -> next cycle x = 0, y = 11.
- Reset mid-frame: assert rst asynchronously at x = 300, y = 200 while rgb_in = 6'b101010 -> x = 0, y = 0, rgb_out = 0, hsync = vsync = 1 before the next clock edge. Normal counting resumes from 0 after release.
